md_unit: RTL and testbench

Iterative multiply/divide unit for the hardware-scheduled pipeline. It executes MULT/MULTU/DIV/DIVU issued from EX over N+2 cycles and owns the architectural HI/LO registers. It drives the stall input of the pipeline control, which deasserts the write enables of the upstream pipeline registers. It also serves MFHI/MFLO/MTHI/MTLO once no operation is pending.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_core.sv | 106 ++++++++++
 rtl/md_unit.sv | 113 +++++++++++
 tb/tb_md_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_DEFAULT_N = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // Iteration counter must hold 0..N.
    function automatic int unsigned md_cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/md_core.sv
// Iterative shift-add multiply / restoring divide datapath on operand magnitudes,
// with combinational sign fix-up of the final HI/LO pair.
module md_core
    import md_pkg::*;
#(
    parameter int unsigned N = MD_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] hi_c,
    output logic [N-1:0] lo_c
);

    localparam int unsigned W2 = 2 * N;

    logic         is_div;
    logic         neg_q;
    logic         neg_r;
    logic         div0;
    logic [N-1:0] addend;
    logic [N-1:0] acc_hi;
    logic [N-1:0] acc_lo;

    logic         op_signed;
    logic         op_div;
    logic         a_neg;
    logic         b_neg;
    logic [N-1:0] mag_a;
    logic [N-1:0] mag_b;

    // Operand decode and magnitudes; the most-negative value maps to 2^(N-1) unsigned.
    always_comb begin
        op_signed = (op == MD_MULT) || (op == MD_DIV);
        op_div    = (op == MD_DIVU) || (op == MD_DIV);
        a_neg     = op_signed & a[N-1];
        b_neg     = op_signed & b[N-1];
        mag_a     = a_neg ? N'(~a + 1'b1) : a;
        mag_b     = b_neg ? N'(~b + 1'b1) : b;
    end

    logic [N:0]   sum;
    logic [N:0]   shifted;
    logic         borrow;
    logic [N-1:0] diff;
    logic [N-1:0] hi_n;
    logic [N-1:0] lo_n;

    // One iteration: multiply shifts the product right, divide shifts the remainder left.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : {(N+1){1'b0}});
        shifted = {acc_hi, acc_lo[N-1]};
        borrow  = shifted < {1'b0, addend};
        diff    = shifted[N-1:0] - addend;
        if (is_div) begin
            hi_n = borrow ? shifted[N-1:0] : diff;
            lo_n = {acc_lo[N-2:0], ~borrow};
        end else begin
            hi_n = sum[N:1];
            lo_n = {sum[0], acc_lo[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            addend <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (load) begin
            is_div <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= op_div && (b == '0);
            addend <= op_div ? mag_b : mag_a;
            acc_hi <= '0;
            acc_lo <= op_div ? mag_a : mag_b;
        end else if (step) begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
        end
    end

    logic [W2-1:0] prod;
    logic [W2-1:0] prod_neg;

    // Sign fix; signed-overflow divide falls out of the N-bit wrap of the negate.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_neg = W2'(~prod + 1'b1);
        if (is_div) begin
            hi_c = neg_r ? N'(~acc_hi + 1'b1) : acc_hi;
            lo_c = div0 ? '1 : (neg_q ? N'(~acc_lo + 1'b1) : acc_lo);
        end else begin
            {hi_c, lo_c} = neg_q ? prod_neg : prod;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: sequencing FSM, architectural HI/LO registers and
// pipeline stall generation around the md_core datapath.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned N = MD_DEFAULT_N
) (
    input  logic         i_CLK,
    input  logic         i_RST_N,
    input  logic         i_start,
    input  logic [1:0]   i_op,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    input  logic         i_mf,
    input  logic         i_mthi,
    input  logic         i_mtlo,
    input  logic [N-1:0] i_wdata,
    output logic         o_busy,
    output logic         o_stall,
    output logic         o_done,
    output logic [N-1:0] o_HI,
    output logic [N-1:0] o_LO
);

    localparam int unsigned CNT_W = md_cnt_width(N);

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             busy;
    logic             done;
    logic [N-1:0]     hi;
    logic [N-1:0]     lo;
    logic             load_c;
    logic             step_c;
    logic             fix_c;
    logic [N-1:0]     core_hi_c;
    logic [N-1:0]     core_lo_c;

    always_comb begin
        state_next = state;
        count_next = count;
        load_c     = 1'b0;
        step_c     = 1'b0;
        fix_c      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    load_c     = 1'b1;
                    count_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                step_c     = 1'b1;
                count_next = count + 1'b1;
                if (count == CNT_W'(N - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                fix_c      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // MT writes only land while idle; the FIX write always takes HI/LO.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            busy  <= (state_next != IDLE);
            done  <= fix_c;
            if (fix_c) begin
                hi <= core_hi_c;
                lo <= core_lo_c;
            end else if (!busy) begin
                if (i_mthi) hi <= i_wdata;
                if (i_mtlo) lo <= i_wdata;
            end
        end
    end

    md_core #(.N(N)) u_core (
        .clk   (i_CLK),
        .rst_n (i_RST_N),
        .load  (load_c),
        .step  (step_c),
        .op    (i_op),
        .a     (i_A),
        .b     (i_B),
        .hi_c  (core_hi_c),
        .lo_c  (core_lo_c)
    );

    // Combinational so EX holds its instruction in the same cycle.
    assign o_stall = busy & (i_start | i_mf | i_mthi | i_mtlo);
    assign o_busy  = busy;
    assign o_done  = done;
    assign o_HI    = hi;
    assign o_LO    = lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases, random operations against an
// arithmetic reference model, stall/MT behaviour and mid-operation reset.
module tb_md_unit;
    import md_pkg::*;

    localparam int N = 32;

    logic          i_CLK;
    logic          i_RST_N;
    logic          i_start;
    logic [1:0]    i_op;
    logic [N-1:0]  i_A;
    logic [N-1:0]  i_B;
    logic          i_mf;
    logic          i_mthi;
    logic          i_mtlo;
    logic [N-1:0]  i_wdata;
    logic          o_busy;
    logic          o_stall;
    logic          o_done;
    logic [N-1:0]  o_HI;
    logic [N-1:0]  o_LO;

    int n_cmp;
    int n_err;
    logic [N-1:0] exp_hi;
    logic [N-1:0] exp_lo;

    md_unit #(.N(N)) dut (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_start (i_start),
        .i_op    (i_op),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_mf    (i_mf),
        .i_mthi  (i_mthi),
        .i_mtlo  (i_mtlo),
        .i_wdata (i_wdata),
        .o_busy  (o_busy),
        .o_stall (o_stall),
        .o_done  (o_done),
        .o_HI    (o_HI),
        .o_LO    (o_LO)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      sp;
        int          sa;
        int          sb;
        int          q;
        int          r;
        case (op)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return p;
            end
            2'b01: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                return 64'(sp);
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = int'(a);
                sb = int'(b);
                q  = sa / sb;
                r  = sa % sb;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    // Issue one op from mid-cycle 0 and follow it to cycle N+2.
    // hold: i_start/i_mf held from cycle 3 (second start), MT poke in cycle 5.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit mt_same,
                          input logic [31:0] ehi, input logic [31:0] elo);
        i_start = 1'b1;
        i_op    = op;
        i_A     = a;
        i_B     = b;
        i_mf    = 1'b0;
        i_mthi  = 1'b0;
        i_mtlo  = 1'b0;
        if (mt_same) begin
            i_mthi  = 1'b1;
            i_mtlo  = 1'b1;
            i_wdata = $urandom;
            exp_hi  = i_wdata;
            exp_lo  = i_wdata;
        end
        @(posedge i_CLK);
        #1;
        i_start = 1'b0;
        i_mthi  = 1'b0;
        i_mtlo  = 1'b0;
        for (int cyc = 1; cyc <= N + 2; cyc++) begin
            @(negedge i_CLK);
            if (hold && cyc == 3) begin
                i_start = 1'b1;
                i_mf    = 1'b1;
                i_op    = 2'($urandom);
                i_A     = $urandom;
                i_B     = $urandom;
            end
            if (hold && cyc == 5) begin
                i_mthi  = 1'b1;
                i_mtlo  = 1'b1;
                i_wdata = $urandom;
            end
            if (hold && cyc == 6) begin
                i_mthi = 1'b0;
                i_mtlo = 1'b0;
            end
            #1;
            check("stall", 32'(o_stall), 32'(hold && cyc >= 3 && cyc <= N + 1));
            if (cyc <= N + 1) begin
                check("busy_run", 32'(o_busy), 32'd1);
                check("done_run", 32'(o_done), 32'd0);
                check("hi_hold", o_HI, exp_hi);
                check("lo_hold", o_LO, exp_lo);
            end else begin
                check("busy_end", 32'(o_busy), 32'd0);
                check("done_end", 32'(o_done), 32'd1);
                check("hi_res", o_HI, ehi);
                check("lo_res", o_LO, elo);
            end
        end
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    // MTHI/MTLO while idle, with a concurrent MF that must not stall.
    task automatic do_mt(input bit h, input bit l, input logic [31:0] d);
        i_mthi  = h;
        i_mtlo  = l;
        i_wdata = d;
        i_mf    = 1'b1;
        #1;
        check("stall_idle", 32'(o_stall), 32'd0);
        @(posedge i_CLK);
        #1;
        i_mthi = 1'b0;
        i_mtlo = 1'b0;
        i_mf   = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        @(negedge i_CLK);
        #1;
        check("mt_hi", o_HI, exp_hi);
        check("mt_lo", o_LO, exp_lo);
        check("mt_done", 32'(o_done), 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] r;
        n_cmp   = 0;
        n_err   = 0;
        i_RST_N = 1'b0;
        i_start = 1'b0;
        i_op    = 2'b00;
        i_A     = '0;
        i_B     = '0;
        i_mf    = 1'b0;
        i_mthi  = 1'b0;
        i_mtlo  = 1'b0;
        i_wdata = '0;
        exp_hi  = '0;
        exp_lo  = '0;
        repeat (2) @(posedge i_CLK);
        @(negedge i_CLK);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_hi", o_HI, 32'd0);
        check("rst_lo", o_LO, 32'd0);
        i_RST_N = 1'b1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 32'h8000_0000);
        run_op(MD_DIVU, 32'd7, 32'd0, 0, 0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 32'h0000_0000);
        run_op(MD_MULT, 32'd7, 32'd3, 1, 0, 32'h0000_0000, 32'h0000_0015);
        run_op(MD_DIVU, 32'd100, 32'd7, 0, 0, 32'h0000_0002, 32'h0000_000E);

        do_mt(1'b1, 1'b0, 32'hAAAA_5555);
        do_mt(1'b0, 1'b1, 32'h1234_5678);
        do_mt(1'b1, 1'b1, 32'hDEAD_BEEF);
        run_op(MD_MULTU, 32'd3, 32'd4, 0, 1, 32'h0000_0000, 32'h0000_000C);

        for (int k = 0; k < 24; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            r = model(rop, ra, rb);
            run_op(rop, ra, rb, 0, 0, r[63:32], r[31:0]);
        end

        // Reset at the edge ending cycle 10 of a divide.
        i_start = 1'b1;
        i_op    = MD_DIVU;
        i_A     = 32'd1000;
        i_B     = 32'd3;
        @(posedge i_CLK);
        #1;
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge i_CLK);
            #1;
        end
        i_RST_N = 1'b0;
        @(negedge i_CLK);
        #1;
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_hi", o_HI, 32'd0);
        check("mrst_lo", o_LO, 32'd0);
        check("mrst_done", 32'(o_done), 32'd0);
        i_RST_N = 1'b1;
        for (int cyc = 0; cyc < N + 4; cyc++) begin
            @(negedge i_CLK);
            #1;
            check("post_rst_done", 32'(o_done), 32'd0);
            check("post_rst_busy", 32'(o_busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
